// File: rtl/conv_round_mac_pipe_if.sv
// Handshake/data bundle for conv_round_mac_pipe.
// The upstream producer uses master and the datapath uses slave.
interface conv_round_mac_pipe_if #(
    parameter int A_W   = 25,
    parameter int B_W   = 18,
    parameter int OUT_W = 16,
    parameter int CNT_W = 16
);
    localparam int P_W = A_W + B_W;

    logic             ce;
    logic             in_valid;
    logic [A_W-1:0]   ain;
    logic [B_W-1:0]   bin;
    logic [P_W-1:0]   cin;
    logic [1:0]       mode;
    logic             clr_cnt;
    logic             out_valid;
    logic [OUT_W-1:0] round_out;
    logic             sat;
    logic [CNT_W-1:0] sat_cnt;

    modport master (
        output ce, in_valid, ain, bin, cin, mode, clr_cnt,
        input  out_valid, round_out, sat, sat_cnt
    );

    modport slave (
        input  ce, in_valid, ain, bin, cin, mode, clr_cnt,
        output out_valid, round_out, sat, sat_cnt
    );
endinterface

// File: rtl/conv_round_mac_pipe.sv
// Four-stage A*B+C datapath with per-sample selectable rounding at FRAC_BITS,
// signed saturation to OUT_W bits and a sticky saturation-event counter.
module conv_round_mac_pipe #(
    parameter int A_W       = 25,
    parameter int B_W       = 18,
    parameter int FRAC_BITS = 4,
    parameter int OUT_W     = 16,
    parameter int CNT_W     = 16
) (
    input logic                 clk,
    input logic                 rst,
    conv_round_mac_pipe_if.slave bus
);
    localparam int P_W = A_W + B_W;
    localparam int S_W = P_W + 1;

    localparam logic signed [S_W:0] MAX_V = {{(S_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [S_W:0] MIN_V = {{(S_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    // Stage 1: input capture
    logic           v1;
    logic [A_W-1:0] a1;
    logic [B_W-1:0] b1;
    logic [P_W-1:0] c1;
    logic [1:0]     m1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            a1 <= '0;
            b1 <= '0;
            c1 <= '0;
            m1 <= '0;
        end else if (bus.ce) begin
            v1 <= bus.in_valid;
            if (bus.in_valid) begin
                a1 <= bus.ain;
                b1 <= bus.bin;
                c1 <= bus.cin;
                m1 <= bus.mode;
            end
        end
    end

    // Operands are sign-extended to full product width so the low P_W bits are exact.
    logic [P_W-1:0] prod_full;
    assign prod_full = {{B_W{a1[A_W-1]}}, a1} * {{A_W{b1[B_W-1]}}, b1};

    // Stage 2: product
    logic           v2;
    logic [P_W-1:0] prod2;
    logic [P_W-1:0] c2;
    logic [1:0]     m2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2    <= 1'b0;
            prod2 <= '0;
            c2    <= '0;
            m2    <= '0;
        end else if (bus.ce) begin
            v2 <= v1;
            if (v1) begin
                prod2 <= prod_full;
                c2    <= c1;
                m2    <= m1;
            end
        end
    end

    // Stage 3: sum with one extra bit so prod + C never wraps
    logic                  v3;
    logic signed [S_W-1:0] sum3;
    logic [1:0]            m3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v3   <= 1'b0;
            sum3 <= '0;
            m3   <= '0;
        end else if (bus.ce) begin
            v3 <= v2;
            if (v2) begin
                sum3 <= {prod2[P_W-1], prod2} + {c2[P_W-1], c2};
                m3   <= m2;
            end
        end
    end

    logic signed [S_W-1:0] int_part;
    logic                  half_bit;
    logic                  rest_bits;
    logic                  inc;
    logic signed [S_W:0]   rounded;
    logic                  sat_next;
    logic [OUT_W-1:0]      res_next;

    always_comb begin
        int_part  = sum3 >>> FRAC_BITS;
        half_bit  = sum3[FRAC_BITS-1];
        rest_bits = |sum3[FRAC_BITS-2:0];
        inc       = 1'b0;
        case (m3)
            2'd0:    inc = 1'b0;
            2'd1:    inc = half_bit;
            2'd2:    inc = half_bit & (rest_bits | int_part[0]);
            default: inc = half_bit & (rest_bits | ~int_part[0]);
        endcase
        rounded  = {int_part[S_W-1], int_part} + {{S_W{1'b0}}, inc};
        sat_next = 1'b0;
        res_next = rounded[OUT_W-1:0];
        if (rounded > MAX_V) begin
            res_next = MAX_V[OUT_W-1:0];
            sat_next = 1'b1;
        end else if (rounded < MIN_V) begin
            res_next = MIN_V[OUT_W-1:0];
            sat_next = 1'b1;
        end
    end

    // Stage 4: result registers hold the last valid result while idle
    logic             out_valid_r;
    logic [OUT_W-1:0] round_out_r;
    logic             sat_r;
    logic [CNT_W-1:0] sat_cnt_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            round_out_r <= '0;
            sat_r       <= 1'b0;
        end else if (bus.ce) begin
            out_valid_r <= v3;
            if (v3) begin
                round_out_r <= res_next;
                sat_r       <= sat_next;
            end
        end
    end

    // Clear wins over increment and works even while the pipeline is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_cnt_r <= '0;
        end else if (bus.clr_cnt) begin
            sat_cnt_r <= '0;
        end else if (bus.ce && v3 && sat_next && !(&sat_cnt_r)) begin
            sat_cnt_r <= sat_cnt_r + CNT_W'(1);
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.round_out = round_out_r;
    assign bus.sat       = sat_r;
    assign bus.sat_cnt   = sat_cnt_r;

endmodule

// File: tb/tb_conv_round_mac_pipe.sv
// Self-checking bench for conv_round_mac_pipe against an arithmetic reference
// model (floor division, fraction compare, clamp) plus an expected-result queue.
module tb_conv_round_mac_pipe;
    localparam int A_W       = 25;
    localparam int B_W       = 18;
    localparam int FRAC_BITS = 4;
    localparam int OUT_W     = 16;
    localparam int CNT_W     = 4;
    localparam int P_W       = A_W + B_W;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    conv_round_mac_pipe_if #(.A_W(A_W), .B_W(B_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) bus ();

    conv_round_mac_pipe #(
        .A_W(A_W), .B_W(B_W), .FRAC_BITS(FRAC_BITS), .OUT_W(OUT_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               due;
        logic [OUT_W-1:0] val;
        bit               s;
    } exp_t;

    exp_t             exp_q[$];
    int               ce_cnt = 0;
    bit               exp_ov = 1'b0;
    logic [OUT_W-1:0] exp_round = '0;
    bit               exp_sat = 1'b0;
    int               exp_cnt = 0;
    int               total = 0;
    int               bad = 0;

    // Real-number rounding of (A*B+C)/2^FRAC_BITS followed by a clamp to OUT_W.
    function automatic void model(input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                                  input logic [P_W-1:0] c, input logic [1:0] m,
                                  output logic [OUT_W-1:0] res, output bit s);
        longint av, bv, cv, sum, scale, half, q, frac, r, hi, lo;
        av    = $signed(a);
        bv    = $signed(b);
        cv    = $signed(c);
        sum   = av * bv + cv;
        scale = longint'(1) << FRAC_BITS;
        half  = scale / 2;
        q     = sum / scale;
        if (sum < 0 && q * scale != sum) q = q - 1;
        frac = sum - q * scale;
        case (m)
            2'd0: r = q;
            2'd1: r = (frac >= half) ? q + 1 : q;
            2'd2: r = (frac > half) ? q + 1 : ((frac == half && (q % 2 != 0)) ? q + 1 : q);
            default: r = (frac > half) ? q + 1 : ((frac == half && (q % 2 == 0)) ? q + 1 : q);
        endcase
        hi = (longint'(1) << (OUT_W - 1)) - 1;
        lo = -hi - 1;
        s  = 1'b0;
        if (r > hi) begin
            r = hi;
            s = 1'b1;
        end else if (r < lo) begin
            r = lo;
            s = 1'b1;
        end
        res = r[OUT_W-1:0];
    endfunction

    function automatic logic [A_W-1:0] rand_a(input bit wide);
        if (wide) return A_W'($urandom);
        return A_W'(int'($urandom_range(0, 16383)) - 8192);
    endfunction

    function automatic logic [B_W-1:0] rand_b(input bit wide);
        if (wide) return B_W'($urandom);
        return B_W'(int'($urandom_range(0, 255)) - 128);
    endfunction

    function automatic logic [P_W-1:0] rand_c(input bit wide);
        if (wide) return P_W'({$urandom, $urandom});
        return P_W'(int'($urandom_range(0, 2097151)) - 1048576);
    endfunction

    // Drives one clock cycle and advances the expected-output model; no checking here.
    task automatic cycle(input bit ce_i, input bit vld_i, input logic [A_W-1:0] a_i,
                         input logic [B_W-1:0] b_i, input logic [P_W-1:0] c_i,
                         input logic [1:0] m_i, input bit clr_i);
        logic [OUT_W-1:0] r;
        bit               s;
        bit               new_ov;
        exp_t             e;
        bus.ce       = ce_i;
        bus.in_valid = vld_i;
        bus.ain      = a_i;
        bus.bin      = b_i;
        bus.cin      = c_i;
        bus.mode     = m_i;
        bus.clr_cnt  = clr_i;
        @(posedge clk);
        new_ov = 1'b0;
        if (ce_i) begin
            ce_cnt++;
            new_ov = (exp_q.size() > 0) && (exp_q[0].due == ce_cnt);
        end
        if (clr_i) exp_cnt = 0;
        else if (new_ov && exp_q[0].s && exp_cnt < CNT_MAX) exp_cnt++;
        if (ce_i) begin
            exp_ov = new_ov;
            if (new_ov) begin
                e         = exp_q.pop_front();
                exp_round = e.val;
                exp_sat   = e.s;
            end
            if (vld_i) begin
                model(a_i, b_i, c_i, m_i, r, s);
                e.due = ce_cnt + 3;
                e.val = r;
                e.s   = s;
                exp_q.push_back(e);
            end
        end
        #1;
    endtask

    task automatic idle();
        cycle(1'b1, 1'b0, '0, '0, '0, 2'd0, 1'b0);
    endtask

    task automatic test_reset();
        bus.ce = 1'b0; bus.in_valid = 1'b0; bus.ain = '0; bus.bin = '0;
        bus.cin = '0; bus.mode = '0; bus.clr_cnt = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({bus.out_valid, bus.round_out, bus.sat, bus.sat_cnt} !== '0) begin
            bad++;
            $display("[TB] FAIL reset got ov=%0b out=%0h sat=%0b cnt=%0d want all zero",
                     bus.out_valid, bus.round_out, bus.sat, bus.sat_cnt);
        end
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_tie_modes();
        logic [A_W-1:0] av[3];
        logic [B_W-1:0] bv[3];
        av[0] = 25'h0000028; bv[0] = 18'h00001;
        av[1] = 25'h1FFFFD8; bv[1] = 18'h00001;
        av[2] = 25'h0000001; bv[2] = 18'h00038;
        for (int i = 0; i < 20; i++) begin
            if (i < 12) cycle(1'b1, 1'b1, av[i/4], bv[i/4], '0, 2'(i % 4), 1'b0);
            else idle();
            total++;
            if ({bus.out_valid, bus.round_out, bus.sat, bus.sat_cnt} !== {exp_ov, exp_round, exp_sat, CNT_W'(exp_cnt)}) begin
                bad++;
                $display("[TB] FAIL tie_modes cyc=%0d got ov=%0b out=%0h sat=%0b cnt=%0d want ov=%0b out=%0h sat=%0b cnt=%0d",
                         i, bus.out_valid, bus.round_out, bus.sat, bus.sat_cnt, exp_ov, exp_round, exp_sat, exp_cnt);
            end
        end
    endtask

    task automatic test_non_tie();
        for (int i = 0; i < 14; i++) begin
            if (i < 8) cycle(1'b1, 1'b1, 25'h28, 18'h1, (i < 4) ? 43'h8 : 43'h7, 2'(i % 4), 1'b0);
            else idle();
            total++;
            if ({bus.out_valid, bus.round_out, bus.sat, bus.sat_cnt} !== {exp_ov, exp_round, exp_sat, CNT_W'(exp_cnt)}) begin
                bad++;
                $display("[TB] FAIL non_tie cyc=%0d got ov=%0b out=%0h sat=%0b cnt=%0d want ov=%0b out=%0h sat=%0b cnt=%0d",
                         i, bus.out_valid, bus.round_out, bus.sat, bus.sat_cnt, exp_ov, exp_round, exp_sat, exp_cnt);
            end
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 40; i++) begin
            if (i == 0) cycle(1'b1, 1'b0, '0, '0, '0, 2'd0, 1'b1);
            else if (i == 1) cycle(1'b1, 1'b1, 25'h0FFFFF, 18'h100, '0, 2'd1, 1'b0);
            else if (i == 2) cycle(1'b1, 1'b1, 25'h1F00000, 18'h100, '0, 2'd2, 1'b0);
            else if (i == 7) cycle(1'b1, 1'b1, 25'h0FFFFF, 18'h100, '0, 2'd0, 1'b0);
            else if (i == 10) cycle(1'b1, 1'b0, '0, '0, '0, 2'd0, 1'b1);
            else if (i >= 14 && i < 34) cycle(1'b1, 1'b1, (i % 2 == 0) ? 25'h0FFFFF : 25'h1F00000, 18'h100, '0, 2'(i % 4), 1'b0);
            else idle();
            total++;
            if ({bus.out_valid, bus.round_out, bus.sat, bus.sat_cnt} !== {exp_ov, exp_round, exp_sat, CNT_W'(exp_cnt)}) begin
                bad++;
                $display("[TB] FAIL saturation cyc=%0d got ov=%0b out=%0h sat=%0b cnt=%0d want ov=%0b out=%0h sat=%0b cnt=%0d",
                         i, bus.out_valid, bus.round_out, bus.sat, bus.sat_cnt, exp_ov, exp_round, exp_sat, exp_cnt);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit             ce_pat[5];
        int             sent;
        logic [A_W-1:0] a;
        logic [B_W-1:0] b;
        logic [P_W-1:0] c;
        logic [1:0]     m;
        ce_pat[0] = 1; ce_pat[1] = 0; ce_pat[2] = 1; ce_pat[3] = 1; ce_pat[4] = 0;
        sent = 0;
        a = rand_a(1'b0); b = rand_b(1'b0); c = rand_c(1'b0); m = 2'($urandom);
        for (int i = 0; i < 30; i++) begin
            cycle(ce_pat[i % 5], sent < 8, a, b, c, m, 1'b0);
            if (ce_pat[i % 5] && sent < 8) begin
                sent++;
                a = rand_a(1'b0); b = rand_b(1'b0); c = rand_c(1'b0); m = 2'($urandom);
            end
            total++;
            if ({bus.out_valid, bus.round_out, bus.sat, bus.sat_cnt} !== {exp_ov, exp_round, exp_sat, CNT_W'(exp_cnt)}) begin
                bad++;
                $display("[TB] FAIL back_to_back cyc=%0d got ov=%0b out=%0h sat=%0b cnt=%0d want ov=%0b out=%0h sat=%0b cnt=%0d",
                         i, bus.out_valid, bus.round_out, bus.sat, bus.sat_cnt, exp_ov, exp_round, exp_sat, exp_cnt);
            end
        end
    endtask

    task automatic test_random();
        bit wide;
        for (int i = 0; i < 300; i++) begin
            wide = ($urandom_range(0, 3) == 0);
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, rand_a(wide), rand_b(wide),
                  rand_c($urandom_range(0, 4) == 0), 2'($urandom), $urandom_range(0, 29) == 0);
            total++;
            if ({bus.out_valid, bus.round_out, bus.sat, bus.sat_cnt} !== {exp_ov, exp_round, exp_sat, CNT_W'(exp_cnt)}) begin
                bad++;
                $display("[TB] FAIL random cyc=%0d got ov=%0b out=%0h sat=%0b cnt=%0d want ov=%0b out=%0h sat=%0b cnt=%0d",
                         i, bus.out_valid, bus.round_out, bus.sat, bus.sat_cnt, exp_ov, exp_round, exp_sat, exp_cnt);
            end
        end
    endtask

    task automatic test_reset_midstream();
        cycle(1'b1, 1'b1, 25'h0FFFFF, 18'h100, '0, 2'd1, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, rand_a(1'b0), rand_b(1'b0), rand_c(1'b0), 2'($urandom), 1'b0);
        rst = 1'b1;
        #1;
        total++;
        if ({bus.out_valid, bus.round_out, bus.sat, bus.sat_cnt} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_midstream got ov=%0b out=%0h sat=%0b cnt=%0d want all zero",
                     bus.out_valid, bus.round_out, bus.sat, bus.sat_cnt);
        end
        exp_q.delete();
        exp_ov = 1'b0; exp_round = '0; exp_sat = 1'b0; exp_cnt = 0;
        @(posedge clk);
        #2 rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idle();
            total++;
            if ({bus.out_valid, bus.round_out, bus.sat, bus.sat_cnt} !== {exp_ov, exp_round, exp_sat, CNT_W'(exp_cnt)}) begin
                bad++;
                $display("[TB] FAIL post_reset cyc=%0d got ov=%0b out=%0h sat=%0b cnt=%0d want ov=%0b out=%0h sat=%0b cnt=%0d",
                         i, bus.out_valid, bus.round_out, bus.sat, bus.sat_cnt, exp_ov, exp_round, exp_sat, exp_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_tie_modes();
        test_non_tie();
        test_saturation();
        test_back_to_back();
        test_random();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
